// File: rtl/wddl_xor3_arb.sv
// wddl_xor3_arb: round-robin arbiter and WDDL precharge/evaluate sequencer sharing one 3-input dual-rail XOR
// ports: clk_in/rst_in (sync, active high); req_in per requester; d{0,1,2}_{p,n}_in operand rails, requester i at [8i+7:8i];
// gnt_out one-hot grant in EVAL/RESP; ack_out one-cycle completion; d_p_out/d_n_out result rails, 0/0 outside RESP;
// busy_out high except in ARB; err_out sticky dual-rail violation flag
module wddl_xor3_8 (
    input  logic [7:0] a_p_i,
    input  logic [7:0] a_n_i,
    input  logic [7:0] b_p_i,
    input  logic [7:0] b_n_i,
    input  logic [7:0] c_p_i,
    input  logic [7:0] c_n_i,
    output logic [7:0] y_p_o,
    output logic [7:0] y_n_o
);
    logic [7:0] t_p, t_n;
    assign t_p   = (a_p_i & b_n_i) | (a_n_i & b_p_i);
    assign t_n   = (a_p_i & b_p_i) | (a_n_i & b_n_i);
    assign y_p_o = (t_p & c_n_i) | (t_n & c_p_i);
    assign y_n_o = (t_p & c_p_i) | (t_n & c_n_i);
endmodule

module wddl_xor3_arb #(
    parameter int NREQ    = 2,
    parameter int PRE_CYC = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NREQ-1:0]   req_in,
    input  logic [8*NREQ-1:0] d0_p_in,
    input  logic [8*NREQ-1:0] d0_n_in,
    input  logic [8*NREQ-1:0] d1_p_in,
    input  logic [8*NREQ-1:0] d1_n_in,
    input  logic [8*NREQ-1:0] d2_p_in,
    input  logic [8*NREQ-1:0] d2_n_in,
    output logic [NREQ-1:0]   gnt_out,
    output logic [NREQ-1:0]   ack_out,
    output logic [7:0]        d_p_out,
    output logic [7:0]        d_n_out,
    output logic              busy_out,
    output logic              err_out
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = PRE_CYC > 1 ? $clog2(PRE_CYC) : 1;
    typedef enum logic [1:0] {PRE, ARB, EVAL, RESP} state_e;
    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [IW-1:0]   rr_q, rr_d, win, j;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [47:0]     op_q, op_d;
    logic [7:0]      res_p_q, res_p_d, res_n_q, res_n_d, y_p, y_n;
    logic            err_q, err_d, found, bad;
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IW'((int'(rr_q) + k) % NREQ);
            if (!found && req_in[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end
    // operand regs hold {d0p,d0n,d1p,d1n,d2p,d2n}; nonzero only during EVAL
    wddl_xor3_8 u_xor (
        .a_p_i(op_q[47:40]), .a_n_i(op_q[39:32]),
        .b_p_i(op_q[31:24]), .b_n_i(op_q[23:16]),
        .c_p_i(op_q[15:8]),  .c_n_i(op_q[7:0]),
        .y_p_o(y_p),         .y_n_o(y_n)
    );
    assign bad = |(~(op_q[47:40] ^ op_q[39:32])) | |(~(op_q[31:24] ^ op_q[23:16])) | |(~(op_q[15:8] ^ op_q[7:0]));
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        op_d    = '0;
        res_p_d = res_p_q;
        res_n_d = res_n_q;
        err_d   = err_q;
        case (state_q)
            PRE: begin
                state_d = pre_q == '0 ? ARB : PRE;
                pre_d   = pre_q == '0 ? pre_q : pre_q - 1'b1;
            end
            ARB: if (found) begin
                state_d = EVAL;
                gnt_d   = NREQ'(1) << win;
                rr_d    = win;
                op_d    = {d0_p_in[{win, 3'b000} +: 8], d0_n_in[{win, 3'b000} +: 8],
                           d1_p_in[{win, 3'b000} +: 8], d1_n_in[{win, 3'b000} +: 8],
                           d2_p_in[{win, 3'b000} +: 8], d2_n_in[{win, 3'b000} +: 8]};
            end
            EVAL: begin
                state_d = RESP;
                res_p_d = y_p;
                res_n_d = y_n;
                err_d   = err_q | bad;
            end
            default: begin
                state_d = PRE;
                pre_d   = PW'(PRE_CYC - 1);
                gnt_d   = '0;
                res_p_d = '0;
                res_n_d = '0;
            end
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= PRE;
            pre_q   <= PW'(PRE_CYC - 1);
            rr_q    <= IW'(NREQ - 1);
            gnt_q   <= '0;
            op_q    <= '0;
            res_p_q <= '0;
            res_n_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            res_p_q <= res_p_d;
            res_n_q <= res_n_d;
            err_q   <= err_d;
        end
    end
    assign gnt_out  = gnt_q;
    assign ack_out  = state_q == RESP ? gnt_q : '0;
    assign d_p_out  = res_p_q;
    assign d_n_out  = res_n_q;
    assign busy_out = state_q != ARB;
    assign err_out  = err_q;
endmodule

// File: tb/tb_wddl_xor3_arb.sv
// tb_wddl_xor3_arb: directed and randomized checks of wddl_xor3_arb against a behavioural arbitration/XOR model
module tb_wddl_xor3_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;
    int tests = 0;
    int fails = 0;
    logic        a_rst, a_busy, a_err;
    logic [1:0]  a_req, a_gnt, a_ack;
    logic [15:0] a_d0p, a_d0n, a_d1p, a_d1n, a_d2p, a_d2n;
    logic [7:0]  a_dp, a_dn;
    logic        b_rst, b_busy, b_err;
    logic [3:0]  b_req, b_gnt, b_ack;
    logic [31:0] b_d0p, b_d0n, b_d1p, b_d1n, b_d2p, b_d2n;
    logic [7:0]  b_dp, b_dn;
    logic [7:0]  aop[2][3];
    logic [7:0]  bop[4][3];
    wddl_xor3_arb #(.NREQ(2), .PRE_CYC(1)) u_a (
        .clk_in(clk), .rst_in(a_rst), .req_in(a_req),
        .d0_p_in(a_d0p), .d0_n_in(a_d0n), .d1_p_in(a_d1p), .d1_n_in(a_d1n), .d2_p_in(a_d2p), .d2_n_in(a_d2n),
        .gnt_out(a_gnt), .ack_out(a_ack), .d_p_out(a_dp), .d_n_out(a_dn), .busy_out(a_busy), .err_out(a_err)
    );
    wddl_xor3_arb #(.NREQ(4), .PRE_CYC(3)) u_b (
        .clk_in(clk), .rst_in(b_rst), .req_in(b_req),
        .d0_p_in(b_d0p), .d0_n_in(b_d0n), .d1_p_in(b_d1p), .d1_n_in(b_d1n), .d2_p_in(b_d2p), .d2_n_in(b_d2n),
        .gnt_out(b_gnt), .ack_out(b_ack), .d_p_out(b_dp), .d_n_out(b_dn), .busy_out(b_busy), .err_out(b_err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic int pick(input int rr, input logic [3:0] req, input int n);
        for (int k = 1; k <= n; k++)
            if (req[(rr + k) % n]) return (rr + k) % n;
        return -1;
    endfunction
    task automatic set_a(input int i, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
        a_d0p[8*i +: 8] = x0; a_d0n[8*i +: 8] = ~x0;
        a_d1p[8*i +: 8] = x1; a_d1n[8*i +: 8] = ~x1;
        a_d2p[8*i +: 8] = x2; a_d2n[8*i +: 8] = ~x2;
        aop[i][0] = x0; aop[i][1] = x1; aop[i][2] = x2;
    endtask
    task automatic set_b(input int i, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
        b_d0p[8*i +: 8] = x0; b_d0n[8*i +: 8] = ~x0;
        b_d1p[8*i +: 8] = x1; b_d1n[8*i +: 8] = ~x1;
        b_d2p[8*i +: 8] = x2; b_d2n[8*i +: 8] = ~x2;
        bop[i][0] = x0; bop[i][1] = x1; bop[i][2] = x2;
    endtask
    task automatic rnd_a(input int i);
        set_a(i, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask
    task automatic rnd_b(input int i);
        set_b(i, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask
    task automatic reset_a();
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
    endtask
    task automatic wait_ack_a(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim && at < 0; i++) begin
            @(negedge clk);
            if (a_ack != 2'b00) at = pcyc;
            else chk("a_precharge", {a_dp, a_dn}, 32'h0);
        end
        if (at < 0) begin
            tests++;
            fails++;
            $error("FAIL a_ack_timeout observed=none expected=ack within %0d cycles", lim);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
    initial begin
        int t, prev, w, ra, rb, exp_ack, arb;
        logic [3:0] exp_oh;
        logic [7:0] exp_dp, exp_dn;
        a_rst = 1'b1; b_rst = 1'b1; a_req = '0; b_req = '0;
        a_d0p = '0; a_d0n = '0; a_d1p = '0; a_d1n = '0; a_d2p = '0; a_d2n = '0;
        b_d0p = '0; b_d0n = '0; b_d1p = '0; b_d1n = '0; b_d2p = '0; b_d2n = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", a_gnt, 0);
        chk("rst_ack", a_ack, 0);
        chk("rst_dp", a_dp, 0);
        chk("rst_dn", a_dn, 0);
        chk("rst_err", a_err, 0);
        chk("rst_busy", a_busy, 1);
        chk("rst_busy_b", b_busy, 1);
        // 1: single request, fixed operands
        set_a(0, 8'h0F, 8'hF0, 8'h3C);
        a_req = 2'b01;
        a_rst = 1'b0;
        @(negedge clk);
        chk("t1_arb_busy", a_busy, 0);
        chk("t1_arb_ack", a_ack, 0);
        @(negedge clk);
        chk("t1_eval_gnt", a_gnt, 2'b01);
        chk("t1_eval_ack", a_ack, 0);
        chk("t1_eval_dp", a_dp, 0);
        @(negedge clk);
        chk("t1_ack", a_ack, 2'b01);
        chk("t1_dp", a_dp, 8'hC3);
        chk("t1_dn", a_dn, 8'h3C);
        chk("t1_err", a_err, 0);
        a_req = 2'b00;
        @(negedge clk);
        chk("t1_post_ack", a_ack, 0);
        chk("t1_post_gnt", a_gnt, 0);
        chk("t1_post_dp", {a_dp, a_dn}, 0);
        chk("t1_post_busy", a_busy, 1);
        // 2: both requesters held, alternating grants
        reset_a();
        rnd_a(0);
        rnd_a(1);
        a_req = 2'b11;
        ra = 1;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_ack_a(8, t);
            w = pick(ra, {2'b00, a_req}, 2);
            exp_oh = 4'(1 << w);
            exp_dp = aop[w][0] ^ aop[w][1] ^ aop[w][2];
            exp_dn = ~exp_dp;
            chk("t2_ack", a_ack, exp_oh);
            chk("t2_dp", a_dp, exp_dp);
            chk("t2_dn", a_dn, exp_dn);
            if (prev >= 0) chk("t2_spacing", t - prev, 4);
            prev = t;
            ra = w;
        end
        a_req = 2'b00;
        // 3: dual-rail violation sets sticky err
        reset_a();
        rnd_a(1);
        a_d0p[15:8] = 8'h01;
        a_d0n[15:8] = 8'h01;
        a_req = 2'b10;
        wait_ack_a(8, t);
        chk("t3_ack", a_ack, 2'b10);
        chk("t3_err", a_err, 1);
        a_req = 2'b01;
        rnd_a(0);
        wait_ack_a(8, t);
        exp_dp = aop[0][0] ^ aop[0][1] ^ aop[0][2];
        chk("t3_ack2", a_ack, 2'b01);
        chk("t3_dp2", a_dp, exp_dp);
        chk("t3_err_sticky", a_err, 1);
        a_req = 2'b00;
        repeat (3) @(negedge clk);
        chk("t3_err_hold", a_err, 1);
        a_rst = 1'b1;
        @(negedge clk);
        chk("t3_err_clr", a_err, 0);
        a_rst = 1'b0;
        // 4: reset during EVAL aborts the operation
        reset_a();
        rnd_a(0);
        a_req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("t4_eval_gnt", a_gnt, 2'b01);
        a_rst = 1'b1;
        a_req = 2'b11;
        @(negedge clk);
        chk("t4_ack", a_ack, 0);
        chk("t4_gnt", a_gnt, 0);
        chk("t4_dpdn", {a_dp, a_dn}, 0);
        chk("t4_busy", a_busy, 1);
        chk("t4_err", a_err, 0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("t4_arb", a_busy, 0);
        @(negedge clk);
        chk("t4_gnt_r0", a_gnt, 2'b01);
        @(negedge clk);
        exp_dp = aop[0][0] ^ aop[0][1] ^ aop[0][2];
        chk("t4_ack_r0", a_ack, 2'b01);
        chk("t4_dp", a_dp, exp_dp);
        a_req = 2'b00;
        // 6: request withdrawn before ARB is never granted, pointer untouched
        b_req = 4'b0100;
        rnd_b(2);
        b_rst = 1'b0;
        @(negedge clk);
        b_req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_gnt", b_gnt, 0);
            chk("t6_ack", b_ack, 0);
        end
        chk("t6_idle", b_busy, 0);
        for (int i = 0; i < 4; i++) rnd_b(i);
        b_req = 4'b1111;
        w = pick(3, b_req, 4);
        exp_oh = 4'(1 << w);
        exp_dp = bop[w][0] ^ bop[w][1] ^ bop[w][2];
        @(negedge clk);
        chk("t6_gnt_rr", b_gnt, exp_oh);
        @(negedge clk);
        chk("t6_ack_rr", b_ack, exp_oh);
        chk("t6_dp_rr", b_dp, exp_dp);
        b_req = 4'b0000;
        // 5: randomized traffic on the 4-requester, 3-precharge instance
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        rb = 3;
        arb = 3;
        exp_ack = -1;
        w = 0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            if (c == exp_ack) begin
                exp_dn = ~exp_dp;
                chk("t5_ack", b_ack, exp_oh);
                chk("t5_gnt", b_gnt, exp_oh);
                chk("t5_dp", b_dp, exp_dp);
                chk("t5_dn", b_dn, exp_dn);
                chk("t5_err", b_err, 0);
                b_req[w] = 1'b0;
                exp_ack = -1;
                arb = c + 3 + 1;
            end else begin
                chk("t5_noack", b_ack, 0);
                chk("t5_precharge", {b_dp, b_dn}, 0);
            end
            if (c == arb) chk("t5_arb_busy", b_busy, 0);
            if (c == exp_ack - 1) rnd_b(w);
            for (int i = 0; i < 4; i++)
                if (!b_req[i] && $urandom_range(3) != 0) begin
                    rnd_b(i);
                    b_req[i] = 1'b1;
                end
            if (c == arb) begin
                if (b_req != 4'b0000) begin
                    w = pick(rb, b_req, 4);
                    rb = w;
                    exp_ack = c + 2;
                    exp_oh = 4'(1 << w);
                    exp_dp = bop[w][0] ^ bop[w][1] ^ bop[w][2];
                end else arb = c + 1;
            end
        end
        b_req = 4'b0000;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
